// File: rtl/spi_controller.sv
`default_nettype none
// ============================================================================
// Module   : spi_controller
// Brief    : SPI master, mode 0 (sck idles low, sampled on rising), MSB first.
//            Frames one DATA_WIDTH-bit transfer with ce and lead/trail gaps.
// Revision : 1.0  initial release
// ============================================================================
module spi_controller #(
  parameter int DATA_WIDTH  = 8,
  parameter int HALF_PERIOD = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  sdi,
  output logic                  sck,
  output logic                  sdo,
  output logic                  ce,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rx_data
);

  localparam int HW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [HW-1:0] H_LAST = HW'(HALF_PERIOD - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEAD  = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_TRAIL = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [HW-1:0]         hcnt_q, hcnt_d;
  logic [BW-1:0]         bcnt_q, bcnt_d;
  logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  done_q, done_d;
  logic                  phase_end;

  assign phase_end = (hcnt_q == H_LAST);

  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    bcnt_d    = bcnt_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    done_d    = 1'b0;

    if (state_q != S_IDLE) begin
      hcnt_d = phase_end ? '0 : hcnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          tx_sh_d = tx_data;
          rx_sh_d = '0;
          bcnt_d  = '0;
          hcnt_d  = '0;
          state_d = S_LEAD;
        end
      end
      S_LEAD: begin
        if (phase_end) state_d = S_HIGH;
      end
      S_HIGH: begin
        if (phase_end) begin
          rx_sh_d = {rx_sh_q[DATA_WIDTH-2:0], sdi};
          if (bcnt_q == B_LAST) begin
            state_d = S_TRAIL;
          end else begin
            // Next bit is shifted up now so sdo is valid from the first LOW cycle.
            bcnt_d  = bcnt_q + 1'b1;
            tx_sh_d = {tx_sh_q[DATA_WIDTH-2:0], 1'b0};
            state_d = S_LOW;
          end
        end
      end
      S_LOW: begin
        if (phase_end) state_d = S_HIGH;
      end
      S_TRAIL: begin
        if (phase_end) begin
          rx_data_d = rx_sh_q;
          done_d    = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      hcnt_q    <= '0;
      bcnt_q    <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      bcnt_q    <= bcnt_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      done_q    <= done_d;
    end
  end

  assign sck     = (state_q == S_HIGH);
  assign busy    = (state_q != S_IDLE);
  assign ce      = busy;
  assign sdo     = ((state_q == S_LEAD) || (state_q == S_HIGH) || (state_q == S_LOW))
                   ? tx_sh_q[DATA_WIDTH-1] : 1'b0;
  assign done    = done_q;
  assign rx_data = rx_data_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_controller
// Brief    : Randomized self-checking bench for spi_controller against a
//            transfer-level model (frame timing, slave contents, received word).
// Revision : 1.0  initial release
// ============================================================================
module tb_spi_controller;

  localparam int W   = 8;
  localparam int H   = 2;
  localparam int W16 = 16;
  localparam int H16 = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic         start;
  logic [W-1:0] tx_data;
  logic         sdi, sck, sdo, ce, busy, done;
  logic [W-1:0] rx_data;
  logic         loop_en;
  logic         sdi_drv;
  assign sdi = loop_en ? sdo : sdi_drv;

  spi_controller #(.DATA_WIDTH(W), .HALF_PERIOD(H)) dut (
    .clk(clk), .reset(reset), .start(start), .tx_data(tx_data), .sdi(sdi),
    .sck(sck), .sdo(sdo), .ce(ce), .busy(busy), .done(done), .rx_data(rx_data)
  );

  // Wide, fast instance with sdi looped back
  logic           s16_start;
  logic [W16-1:0] s16_tx;
  logic           s16_sck, s16_sdo, s16_ce, s16_busy, s16_done;
  logic [W16-1:0] s16_rx;

  spi_controller #(.DATA_WIDTH(W16), .HALF_PERIOD(H16)) dut16 (
    .clk(clk), .reset(reset), .start(s16_start), .tx_data(s16_tx), .sdi(s16_sdo),
    .sck(s16_sck), .sdo(s16_sdo), .ce(s16_ce), .busy(s16_busy), .done(s16_done),
    .rx_data(s16_rx)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Transfer-level observations
  logic [W-1:0] slave;
  logic [W-1:0] periph;
  int           rises, falls, sdo_unstable, ce_bad;
  int           busy_first, busy_last, busy_cnt;
  int           done_cyc[$];
  logic         sck_prev, sdo_at_rise;
  logic [127:0] ce_hist;

  task automatic clear_mon();
    slave = '0; rises = 0; falls = 0; sdo_unstable = 0; ce_bad = 0;
    busy_first = -1; busy_last = -1; busy_cnt = 0;
    done_cyc.delete();
    sck_prev = 1'b0; sdo_at_rise = 1'b0; ce_hist = '0;
    sdi_drv = periph[W-1];
  endtask

  // Called mid-cycle; the peripheral model shifts its word out on sck falling.
  task automatic mon(input int cyc);
    if (sck && !sck_prev) begin
      rises++;
      slave = {slave[W-2:0], sdo};
      sdo_at_rise = sdo;
      if (!ce) ce_bad++;
    end
    if (sck && sck_prev && (sdo !== sdo_at_rise)) sdo_unstable++;
    if (!sck && sck_prev) falls++;
    sck_prev = sck;
    if (busy) begin
      if (busy_first < 0) busy_first = cyc;
      busy_last = cyc;
      busy_cnt++;
    end
    if (ce !== busy) ce_bad++;
    if (cyc < 128) ce_hist[cyc] = ce;
    if (done) done_cyc.push_back(cyc);
    sdi_drv = (falls < W) ? periph[W-1-falls] : 1'b0;
  endtask

  // Cycle k is the period after edge k; start is sampled at edge 0.
  task automatic run_xfer(input logic [W-1:0] tx, input bit loop, input logic [W-1:0] pw,
                          input bit inject, input bit hold, input int ncyc);
    @(negedge clk);
    tx_data = tx; start = 1'b1; periph = pw; loop_en = loop;
    clear_mon();
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      @(negedge clk);
      start = hold;
      if (inject && (cyc == 5 || cyc == 20)) begin
        start   = 1'b1;
        tx_data = ~tx;
      end
      mon(cyc);
    end
    start = 1'b0;
  endtask

  task automatic check_single(input string tag, input logic [W-1:0] tx, input logic [W-1:0] exp_rx);
    int span;
    span = (2 * W + 1) * H;
    check({tag, " busy_first"}, busy_first, 1);
    check({tag, " busy_last"}, busy_last, span);
    check({tag, " busy_cnt"}, busy_cnt, span);
    check({tag, " done_count"}, done_cyc.size(), 1);
    check({tag, " done_cycle"}, (done_cyc.size() > 0) ? done_cyc[0] : -1, span + 1);
    check({tag, " sck_rises"}, rises, W);
    check({tag, " slave"}, slave, tx);
    check({tag, " sdo_unstable"}, sdo_unstable, 0);
    check({tag, " ce_frame"}, ce_bad, 0);
    check({tag, " rx_data"}, rx_data, exp_rx);
  endtask

  initial begin
    logic [W-1:0] t, p;
    bit           lp, inj;
    reset = 1'b1; start = 1'b0; tx_data = '0; loop_en = 1'b0; sdi_drv = 1'b0; periph = '0;
    s16_start = 1'b0; s16_tx = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset sck", sck, 0);
    check("reset ce", ce, 0);
    check("reset sdo", sdo, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset rx_data", rx_data, 0);
    reset = 1'b0;

    // Loopback of 0xA5: sdo sequence observed by the slave equals tx
    run_xfer(8'hA5, 1'b1, 8'h00, 1'b0, 1'b0, 40);
    check_single("a5_loop", 8'hA5, 8'hA5);

    // Slave receives 0x3C while the peripheral returns 0xC3
    run_xfer(8'h3C, 1'b0, 8'hC3, 1'b0, 1'b0, 40);
    check_single("3c_c3", 8'h3C, 8'hC3);

    // Mid-transfer start pulses and tx_data changes are ignored
    run_xfer(8'hA5, 1'b1, 8'h00, 1'b1, 1'b0, 40);
    check_single("ignore_start", 8'hA5, 8'hA5);

    // start held through done: back-to-back frames with a single ce-low cycle
    run_xfer(8'h5A, 1'b1, 8'h00, 1'b0, 1'b1, 75);
    check("b2b done_count", done_cyc.size(), 2);
    check("b2b done0", (done_cyc.size() > 0) ? done_cyc[0] : -1, (2 * W + 1) * H + 1);
    check("b2b done1", (done_cyc.size() > 1) ? done_cyc[1] : -1, 2 * ((2 * W + 1) * H + 1));
    check("b2b ce_gap", {ce_hist[(2*W+1)*H], ce_hist[(2*W+1)*H+1], ce_hist[(2*W+1)*H+2]}, 3'b101);
    check("b2b rx_data", rx_data, 8'h5A);

    // Reset asserted during cycle 12 of a transfer
    @(negedge clk);
    tx_data = 8'hE7; start = 1'b1; loop_en = 1'b1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst sck", sck, 0);
    check("midrst ce", ce, 0);
    check("midrst sdo", sdo, 0);
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst rx_data", rx_data, 0);
    repeat (30) @(negedge clk);
    check("midrst no_update", {done, rx_data}, 9'h000);
    run_xfer(8'h96, 1'b0, 8'h69, 1'b0, 1'b0, 40);
    check_single("after_rst", 8'h96, 8'h69);

    // Randomized transfers
    for (int n = 0; n < 12; n++) begin
      t   = 8'($urandom);
      p   = 8'($urandom);
      lp  = 1'($urandom_range(0, 1));
      inj = 1'($urandom_range(0, 1));
      run_xfer(t, lp, p, inj, 1'b0, 40);
      check_single($sformatf("rand%0d", n), t, lp ? t : p);
    end

    // HALF_PERIOD=1, DATA_WIDTH=16 loopback of 0x8001
    begin
      int bf, bl, bc, dc, r16;
      logic sp;
      bf = -1; bl = -1; bc = 0; dc = -1; r16 = 0; sp = 1'b0;
      @(negedge clk);
      s16_tx = 16'h8001; s16_start = 1'b1;
      for (int cyc = 1; cyc <= 45; cyc++) begin
        @(negedge clk);
        s16_start = 1'b0;
        if (s16_sck && !sp) r16++;
        sp = s16_sck;
        if (s16_busy) begin
          if (bf < 0) bf = cyc;
          bl = cyc;
          bc++;
        end
        if (s16_done && dc < 0) dc = cyc;
      end
      check("w16 busy_first", bf, 1);
      check("w16 busy_cnt", bc, (2 * W16 + 1) * H16);
      check("w16 busy_last", bl, (2 * W16 + 1) * H16);
      check("w16 done_cycle", dc, (2 * W16 + 1) * H16 + 1);
      check("w16 sck_rises", r16, W16);
      check("w16 rx_data", s16_rx, 16'h8001);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
